// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receive front-end.
package i2s_pkg;

  localparam int unsigned DEFAULT_SLOT_BITS = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_t;

  // Half-period of i2s_clk in system clocks, truncated and never below 1.
  function automatic int unsigned calc_half_div(input int unsigned clk_freq,
                                                input int unsigned i2s_freq);
    int unsigned div;
    div = (i2s_freq == 0) ? 1 : clk_freq / (2 * i2s_freq);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock divider with rise/fall event strobes; en_i=0 parks the clock low and clears it.
module i2s_clk_gen #(
  parameter int unsigned HALF_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HALF_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            wrap;

  assign wrap = en_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  // Strobes are high in the cycle whose closing edge toggles sck.
  assign rise_o = wrap && !sck_q;
  assign fall_o = wrap && sck_q;
  assign sck_o  = sck_q;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S master receive front-end: bit clock/word select generation and sample deserialisation.
// Define I2S_RX_STEREO_EN to capture both channels; by default only left slots are captured.
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned I2S_CLK_FREQ = 1_500_000,
  parameter int unsigned DATA_SIZE    = 24,
  parameter int unsigned SLOT_BITS    = DEFAULT_SLOT_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  output logic                 i2s_clk_o,
  output logic                 i2s_ws_o,
  input  logic                 i2s_sd_i,
  output logic [DATA_SIZE-1:0] sample_data_o,
  output logic                 sample_channel_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 overrun_o
);

  localparam int unsigned HalfDiv = calc_half_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int unsigned BitW    = $clog2(SLOT_BITS);
  localparam logic [BitW-1:0] BitMax  = BitW'(SLOT_BITS - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_SIZE);

  logic                 rise, fall;
  logic [1:0]           sd_sync_q;
  logic                 sd_s;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  i2s_chan_t            ws_q, ws_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  i2s_chan_t            chan_q, chan_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 slot_ok, complete, load;
  i2s_chan_t            load_chan;

  i2s_clk_gen #(
    .HALF_DIV(HalfDiv)
  ) u_clk_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (enable_i),
    .sck_o (i2s_clk_o),
    .rise_o(rise),
    .fall_o(fall)
  );

`ifdef I2S_RX_STEREO_EN
  assign slot_ok   = 1'b1;
  assign load_chan = ws_q;
`else
  assign slot_ok   = (ws_q == CH_LEFT);
  assign load_chan = CH_LEFT;
`endif

  assign sd_s = sd_sync_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    shift_d   = shift_q;
    if (!enable_i) begin
      bit_cnt_d = '0;
      ws_d      = CH_LEFT;
      shift_d   = '0;
    end else begin
      // Slot bit 0 is the one-bit I2S delay; bits 1..DATA_SIZE carry the sample MSB first.
      if (rise && (bit_cnt_q != '0) && (bit_cnt_q <= BitLast)) begin
        shift_d = (shift_q << 1) | DATA_SIZE'(sd_s);
      end
      if (fall) begin
        if (bit_cnt_q == BitMax) begin
          bit_cnt_d = '0;
          ws_d      = (ws_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  assign complete = enable_i && rise && (bit_cnt_q == BitLast) && slot_ok;
  assign load     = complete && (!valid_q || sample_ready_i);

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    chan_d    = chan_q;
    overrun_d = complete && !load;
    if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_d;
      chan_d  = load_chan;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sd_sync_q <= '0;
      bit_cnt_q <= '0;
      ws_q      <= CH_LEFT;
      shift_q   <= '0;
      data_q    <= '0;
      chan_q    <= CH_LEFT;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sd_sync_q <= {sd_sync_q[0], i2s_sd_i};
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign i2s_ws_o         = ws_q;
  assign sample_data_o    = data_q;
  assign sample_channel_o = chan_q;
  assign sample_valid_o   = valid_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Scoreboard bench for i2s_rx_capture: a microphone model drives queued words, a monitor checks.
module tb_i2s_rx_capture;

  localparam int KAcc  = 0;  // sample expected on the output
  localparam int KDrop = 1;  // sample expected to be dropped with an overrun pulse
  localparam int KIgn  = 2;  // slot expected to produce nothing
`ifdef I2S_RX_STEREO_EN
  localparam int RAcc = KAcc;
  localparam int RDrop = KDrop;
  localparam int OvrB = 3;
`else
  localparam int RAcc = KIgn;
  localparam int RDrop = KIgn;
  localparam int OvrB = 1;
`endif

  typedef struct {
    logic        ch;
    logic [23:0] word;
    int          kind;
  } stim_t;

  typedef struct {
    logic        ch;
    logic [23:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        i2s_sd = 1'b1;
  logic        sample_ready = 1'b1;
  logic        i2s_clk, i2s_ws, sample_channel, sample_valid, overrun;
  logic [23:0] sample_data;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    exp_ovr = 0;
  int    ovr_seen = 0;

  always #5 clk = ~clk;

  i2s_rx_capture dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .i2s_clk_o       (i2s_clk),
    .i2s_ws_o        (i2s_ws),
    .i2s_sd_i        (i2s_sd),
    .sample_data_o   (sample_data),
    .sample_channel_o(sample_channel),
    .sample_valid_o  (sample_valid),
    .sample_ready_i  (sample_ready),
    .overrun_o       (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event did not occur", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i2s_clk"}, {31'd0, i2s_clk}, 32'd0);
    check({tag, "_i2s_ws"}, {31'd0, i2s_ws}, 32'd0);
    check({tag, "_data"}, {8'd0, sample_data}, 32'd0);
    check({tag, "_channel"}, {31'd0, sample_channel}, 32'd0);
    check({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail(name);
  endtask

  // Microphone: data changes after each i2s_clk fall; MSB one bit after the ws edge.
  int    pos = 0;
  logic  mic_sck_q = 1'b0;
  logic  mic_ws_q = 1'b0;
  stim_t cur;
  bit    cur_on = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || !enable) begin
      pos = 0;
      cur_on = 1'b0;
    end else if (mic_sck_q && !i2s_clk) begin
      if (i2s_ws !== mic_ws_q) begin
        pos = 0;
      end else begin
        pos++;
        if (pos == 1) begin
          cur_on = 1'b0;
          if (stim_q.size() > 0 && stim_q[0].ch == i2s_ws) begin
            cur = stim_q.pop_front();
            cur_on = 1'b1;
            if (cur.kind == KAcc) exp_q.push_back('{ch: cur.ch, word: cur.word});
            else if (cur.kind == KDrop) exp_ovr++;
          end
        end
      end
    end
    mic_sck_q = i2s_clk;
    mic_ws_q  = i2s_ws;
    if (pos >= 1 && pos <= 24) i2s_sd = cur_on ? cur.word[24-pos] : 1'b0;
    else i2s_sd = 1'b1;  // delay bit and unused slot bits must be ignored
  end

  // Monitor: scoreboard pops, hold stability, load latency and bus timing.
  int          cyc = 0;
  int          last_rise = 0;
  int          last_ws = 0;
  bit          have_rise = 1'b0;
  bit          have_ws = 1'b0;
  logic        prev_rstn = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic        prev_sck = 1'b0, prev_ws = 1'b0, prev_en = 1'b0;
  logic [23:0] prev_data = '0;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: got data %h ch %0d, expected no sample", sample_data,
                   sample_channel);
        end else begin
          e = exp_q.pop_front();
          check("sample_data", {8'd0, sample_data}, {8'd0, e.word});
          check("sample_channel", {31'd0, sample_channel}, {31'd0, e.ch});
        end
      end
      if (overrun) ovr_seen++;
      if (prev_rstn && prev_valid && !prev_ready) begin
        check("hold_valid", {31'd0, sample_valid}, 32'd1);
        check("hold_data", {8'd0, sample_data}, {8'd0, prev_data});
      end
      if (prev_rstn && !prev_valid && sample_valid)
        check("valid_with_sck_rise", {30'd0, prev_sck, i2s_clk}, 32'd1);
      if (enable && prev_en && prev_rstn) begin
        if (!prev_sck && i2s_clk) begin
          if (have_rise) check("sck_period", cyc - last_rise, 32'd32);
          have_rise = 1'b1;
          last_rise = cyc;
        end
        if (prev_ws !== i2s_ws) begin
          check("ws_on_sck_fall", {30'd0, prev_sck, i2s_clk}, 32'd2);
          if (have_ws) check("ws_half_period", cyc - last_ws, 32'd1024);
          have_ws = 1'b1;
          last_ws = cyc;
        end
      end else begin
        have_rise = 1'b0;
        have_ws = 1'b0;
      end
    end else begin
      have_rise = 1'b0;
      have_ws = 1'b0;
    end
    prev_rstn  = rst_n;
    prev_valid = sample_valid;
    prev_ready = sample_ready;
    prev_data  = sample_data;
    prev_sck   = i2s_clk;
    prev_ws    = i2s_ws;
    prev_en    = enable;
  end

  initial begin
    int n;
    int early;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic capture, both channels.
    stim_q.push_back('{ch: 1'b0, word: 24'hA5C3F1, kind: KAcc});
    stim_q.push_back('{ch: 1'b1, word: 24'h123456, kind: RAcc});
    stim_q.push_back('{ch: 1'b0, word: 24'h5A5A5A, kind: KAcc});
    stim_q.push_back('{ch: 1'b1, word: 24'h000FFF, kind: RAcc});
    @(posedge clk);
    #1 enable = 1'b1;
    wait_idle("phase_basic", 8000);

    // Back-pressure: first sample held, later ones dropped.
    @(posedge clk);
    #1 sample_ready = 1'b0;
    stim_q.push_back('{ch: 1'b0, word: 24'h111111, kind: KAcc});
    stim_q.push_back('{ch: 1'b1, word: 24'h222222, kind: RDrop});
    stim_q.push_back('{ch: 1'b0, word: 24'h333333, kind: KDrop});
    stim_q.push_back('{ch: 1'b1, word: 24'h444444, kind: RDrop});
    stim_q.push_back('{ch: 1'b0, word: 24'h666666, kind: KAcc});
    stim_q.push_back('{ch: 1'b1, word: 24'h777777, kind: RAcc});
    n = 0;
    while (ovr_seen < OvrB && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) timeout_fail("wait_overruns");
    @(posedge clk);
    #1 sample_ready = 1'b1;
    wait_idle("phase_backpressure", 8000);
    check("overrun_count_bp", ovr_seen, OvrB);

    // Disable mid-slot at bit 10: partial sample discarded.
    stim_q.push_back('{ch: 1'b0, word: 24'hFFFFFF, kind: KIgn});
    n = 0;
    while (!(cur_on && cur.kind == KIgn && cur.ch == 1'b0 && pos == 10) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) timeout_fail("wait_bit10");
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("disabled_i2s_clk", {31'd0, i2s_clk}, 32'd0);
    check("disabled_i2s_ws", {31'd0, i2s_ws}, 32'd0);
    stim_q.push_back('{ch: 1'b0, word: 24'h000001, kind: KAcc});
    stim_q.push_back('{ch: 1'b1, word: 24'h00ABCD, kind: RAcc});
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    wait_idle("phase_reenable", 5000);

    // Asynchronous reset while a sample is held.
    @(posedge clk);
    #1 sample_ready = 1'b0;
    stim_q.push_back('{ch: 1'b0, word: 24'hABCDEF, kind: KAcc});
    n = 0;
    while (!sample_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) timeout_fail("wait_held_valid");
    check("held_before_reset", {8'd0, sample_data}, 32'h00ABCDEF);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    exp_q.delete();
    stim_q.delete();
    sample_ready = 1'b1;
    stim_q.push_back('{ch: 1'b0, word: 24'h0F0F0F, kind: KAcc});
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    early = 0;
    repeat (700) begin
      @(negedge clk);
      if (sample_valid) early++;
    end
    check("no_valid_before_full_slot", early, 32'd0);
    wait_idle("phase_after_reset", 3000);

    check("overrun_total", ovr_seen, exp_ovr);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
